// File: rtl/fram_pkg.sv
// fram_pkg: shared defaults and types for the result-RAM stream reader.
package fram_pkg;

    localparam int FRAM_ADDR_W      = 10;
    localparam int FRAM_DATA_W      = 32;
    localparam int FRAM_NUM_SAMPLES = 1000;
    localparam int FRAM_RD_LAT      = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    typedef logic [FRAM_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fram_stream_reader_if.sv
// fram_stream_reader_if: result-RAM read port plus the valid/ready sample stream.
interface fram_stream_reader_if
    import fram_pkg::*;
#(
    parameter int ADDR_W = FRAM_ADDR_W,
    parameter int DATA_W = FRAM_DATA_W
);

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output ram_addr, ram_rd, m_valid, m_data, m_last,
        input  ram_dout, m_ready
    );

    modport slave (
        input  ram_addr, ram_rd, m_valid, m_data, m_last,
        output ram_dout, m_ready
    );

endinterface

// File: rtl/fram_out_fifo.sv
// fram_out_fifo: small show-ahead FIFO holding words returned by the result RAM.
module fram_out_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop)  rp <= nxt(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout = mem[rp];

endmodule

// File: rtl/fram_stream_reader.sv
// fram_stream_reader: drains the result RAM onto a valid/ready stream with backpressure.
// FRAM_READER_CHKSUM_EN adds chk_sum, a running sum of every transferred word.
module fram_stream_reader
    import fram_pkg::*;
#(
    parameter int ADDR_W      = FRAM_ADDR_W,
    parameter int DATA_W      = FRAM_DATA_W,
    parameter int NUM_SAMPLES = FRAM_NUM_SAMPLES,
    parameter int RD_LAT      = FRAM_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    fram_stream_reader_if.master bus,
    output logic busy,
    output logic done
`ifdef FRAM_READER_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_sum
`endif
);

    localparam int DEPTH = RD_LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = ADDR_W + 1;
    localparam logic [IW-1:0] N_IDX    = IW'(NUM_SAMPLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SAMPLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     out_idx;
    logic [RD_LAT-1:0] rd_pipe;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     fifo_cnt;
    logic [DATA_W-1:0] fifo_dout;
    logic ret_valid, fifo_empty, issue, xfer, push, pop, start_run;

    assign ret_valid  = rd_pipe[RD_LAT-1];
    assign fifo_empty = (fifo_cnt == '0);
    assign start_run  = (state == IDLE) && start;

    // Only issue when the FIFO can absorb every outstanding read.
    assign issue = (state == RUN) && (rd_idx < N_IDX) &&
                   (({1'b0, fifo_cnt} + {1'b0, in_flight}) < (CW+1)'(DEPTH));

    // Empty FIFO lets returning data bypass straight to the stream.
    assign bus.m_valid  = (state == RUN) && (!fifo_empty || ret_valid);
    assign bus.m_data   = !fifo_empty ? fifo_dout :
                          (ret_valid ? bus.ram_dout : '0);
    assign bus.m_last   = bus.m_valid && (out_idx == LAST_IDX);
    assign bus.ram_rd   = issue;
    assign bus.ram_addr = issue ? rd_idx[ADDR_W-1:0] : '0;

    assign xfer = bus.m_valid && bus.m_ready;
    assign pop  = xfer && !fifo_empty;
    assign push = ret_valid && !(fifo_empty && xfer);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (xfer && bus.m_last) state_nx = FLUSH;
            FLUSH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx    <= '0;
            out_idx   <= '0;
            rd_pipe   <= '0;
            in_flight <= '0;
        end else begin
            rd_pipe   <= (rd_pipe << 1) | RD_LAT'(issue);
            in_flight <= in_flight + CW'(issue) - CW'(ret_valid);
            if (start_run) begin
                rd_idx  <= '0;
                out_idx <= '0;
            end else begin
                if (issue) rd_idx  <= rd_idx + 1'b1;
                if (xfer)  out_idx <= out_idx + 1'b1;
            end
        end
    end

    fram_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.ram_dout),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

`ifdef FRAM_READER_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start_run) chk_sum <= '0;
        else if (xfer)        chk_sum <= chk_sum + bus.m_data;
    end
`endif

endmodule

// File: tb/tb_fram_stream_reader.sv
// tb_fram_stream_reader: three reader instances (latency 1/3/2, one with a
// single sample) checked cycle by cycle against a beat-level stream model.
module tb_fram_stream_reader;
    import fram_pkg::*;

    localparam int AW = 10;
    localparam int N  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    fram_stream_reader_if #(.ADDR_W(AW), .DATA_W(32)) b0 (), b1 (), b2 ();

    logic busy0, busy1, busy2, done0, done1, done2;
    logic [31:0] cs0, cs1, cs2;

    fram_stream_reader #(.ADDR_W(AW), .DATA_W(32), .NUM_SAMPLES(N), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(b0), .busy(busy0), .done(done0)
`ifdef FRAM_READER_CHKSUM_EN
        , .chk_sum(cs0)
`endif
    );

    fram_stream_reader #(.ADDR_W(AW), .DATA_W(32), .NUM_SAMPLES(N), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .bus(b1), .busy(busy1), .done(done1)
`ifdef FRAM_READER_CHKSUM_EN
        , .chk_sum(cs1)
`endif
    );

    fram_stream_reader #(.ADDR_W(AW), .DATA_W(32), .NUM_SAMPLES(1), .RD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .bus(b2), .busy(busy2), .done(done2)
`ifdef FRAM_READER_CHKSUM_EN
        , .chk_sum(cs2)
`endif
    );

`ifndef FRAM_READER_CHKSUM_EN
    assign cs0 = '0;
    assign cs1 = '0;
    assign cs2 = '0;
`endif

    // Result RAM with per-instance read latency.
    sample_t mem [1024];
    logic [31:0] r0, r3a, r3b, r3c, r2a, r2b;
    always @(posedge clk) begin
        r0  <= mem[b0.ram_addr];
        r3a <= mem[b1.ram_addr];
        r3b <= r3a;
        r3c <= r3b;
        r2a <= mem[b2.ram_addr];
        r2b <= r2a;
    end
    assign b0.ram_dout = r0;
    assign b1.ram_dout = r3c;
    assign b2.ram_dout = r2b;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    int lat [3] = '{1, 3, 2};
    int ns  [3] = '{N, N, 1};
    bit run [3], fin [3], pv [3], fr [3];
    int ei [3], ri [3], sc [3], fv [3], dones [3];
    logic [31:0] pd [3], csum [3];
    bit inrst = 1'b0;
    bit rnd_ready = 1'b0;
    int cyc = 0;

    task automatic mon(input int k, input logic v, r, l, dn, bsy, rd,
                       input logic [31:0] d, input logic [AW-1:0] a,
                       input logic [31:0] cs);
        bit was_run = run[k];
        chk("busy", bsy, run[k]);
        chk("done", dn, fin[k]);
        if (fin[k]) begin
`ifdef FRAM_READER_CHKSUM_EN
            chk("chk_sum", cs, csum[k]);
`endif
            fin[k] = 0;
            run[k] = 0;
            dones[k]++;
        end
        if (!was_run) begin
            chk("idle_valid", v, 0);
            chk("idle_rd", rd, 0);
        end
        if (inrst) begin
            chk("rst_data", d, 0);
            chk("rst_last", l, 0);
            chk("rst_addr", a, 0);
        end
        if (pv[k]) begin
            chk("hold_valid", v, 1);
            chk("hold_data", d, pd[k]);
        end
        if (rd) begin
            chk("rd_addr", a, ri[k]);
            chk("rd_ok", was_run && ri[k] < ns[k] && (ri[k] - ei[k]) <= lat[k], 1);
            ri[k]++;
        end
        if (v && was_run && fv[k] < 0) begin
            fv[k] = cyc;
            chk("first_valid", cyc - sc[k], lat[k] + 1);
        end
        if (v && r) begin
            if (ei[k] < ns[k]) begin
                chk("data", d, mem[ei[k]]);
                chk("last", l, ei[k] == ns[k] - 1);
                csum[k] = csum[k] + mem[ei[k]];
                ei[k]++;
                if (ei[k] == ns[k]) begin
                    fin[k] = 1;
                    if (fr[k]) chk("burst", cyc - fv[k], ns[k] - 1);
                end
            end else begin
                chk("extra_beat", 1, 0);
            end
        end
        pv[k] = v && !r;
        pd[k] = d;
        if (rst) begin
            run[k] = 0;
            fin[k] = 0;
            pv[k]  = 0;
        end else if (start && !was_run) begin
            run[k]  = 1;
            ei[k]   = 0;
            ri[k]   = 0;
            sc[k]   = cyc;
            fv[k]   = -1;
            csum[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, b0.m_valid, b0.m_ready, b0.m_last, done0, busy0, b0.ram_rd, b0.m_data, b0.ram_addr, cs0);
        mon(1, b1.m_valid, b1.m_ready, b1.m_last, done1, busy1, b1.ram_rd, b1.m_data, b1.ram_addr, cs1);
        mon(2, b2.m_valid, b2.m_ready, b2.m_last, done2, busy2, b2.ram_rd, b2.m_data, b2.ram_addr, cs2);
        inrst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((run[0] || run[1] || run[2]) && n < 20000) begin
            tick();
            n++;
        end
        chk("idle_timeout", run[0] || run[1] || run[2], 0);
    endtask

    task automatic wait_beats(input int b);
        int n = 0;
        while (ei[0] < b && n < 20000) begin
            tick();
            n++;
        end
        chk("beat_timeout", ei[0] >= b, 1);
    endtask

    initial begin
        b0.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b0.m_ready = rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    initial begin
        b1.m_ready = 1'b1;
        b2.m_ready = 1'b1;
        fr = '{1, 1, 1};
        for (int i = 0; i < 1024; i++) mem[i] = sample_t'(i);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        pulse_start();
        wait_idle();
        fr[0] = 0;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        rnd_ready = 1'b1;
        pulse_start();
        wait_beats(10);
        pulse_start();
        wait_idle();

        pulse_start();
        wait_beats(501);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        pulse_start();
        wait_idle();

        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        repeat (5) tick();

        chk("done_count", dones[0], 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
